clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 96 +++++++++
 tb/tb_clk_period_meter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous signal in clockin cycles
module clk_period_meter #(
  parameter int W       = 24,
  parameter int TIMEOUT = 16777215
) (
  input  logic         clockin,
  input  logic         reset_n,
  input  logic         sigin,
  output logic         edge_tick,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         timeout
);
  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;
  localparam logic [W-1:0] CMAX = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE  = W'(1);
  logic s1_q, s2_q, s3_q, armed_q, tick_q;
  logic [1:0] fill_q;
  logic rise;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic valid_q, valid_d, timeout_q, timeout_d;
  // armed_q blocks a false rise when sigin is already high at reset release:
  // a rise only counts once a genuine low sample has passed through s2.
  assign rise = s2_q & ~s3_q & armed_q;
  // synchronizer, history flop, arming and edge pulse
  always_ff @(posedge clockin or negedge reset_n)
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= sigin;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~s2_q);
      tick_q  <= rise;
    end
  // measurement state register
  always_ff @(posedge clockin or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  // next-state: count between rises, capture on rise, stall at the timeout limit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q + ONE;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CMAX) begin
          state_d   = STALLED;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STALLED: begin
        if (rise) begin
          state_d   = MEASURE;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign edge_tick    = tick_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of clk_period_meter with default and short timeout
module tb_clk_period_meter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sigin = 1'b0;
  logic edge_tick_a, valid_a, timeout_a;
  logic [23:0] period_a;
  logic edge_tick_b, valid_b, timeout_b;
  logic [23:0] period_b;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ticks_a = 0, valids_a = 0, dbl_a = 0, orphan_a = 0;
  int ticks_b = 0, valids_b = 0, to_cyc_b = 0, last_tick_b = 0, to_rise_b = 0;
  logic ptick_a = 1'b0, pto_b = 1'b0;

  clk_period_meter dut_a (
    .clockin(clk), .reset_n(reset_n), .sigin(sigin),
    .edge_tick(edge_tick_a), .period(period_a), .period_valid(valid_a), .timeout(timeout_a)
  );
  clk_period_meter #(.W(24), .TIMEOUT(100)) dut_b (
    .clockin(clk), .reset_n(reset_n), .sigin(sigin),
    .edge_tick(edge_tick_b), .period(period_b), .period_valid(valid_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  // event monitor, sampled away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (edge_tick_a === 1'b1) ticks_a++;
    if (valid_a === 1'b1) valids_a++;
    if (valid_a === 1'b1 && edge_tick_a !== 1'b1) orphan_a++;
    if (edge_tick_a === 1'b1 && ptick_a === 1'b1) dbl_a++;
    ptick_a = edge_tick_a;
    if (edge_tick_b === 1'b1) begin ticks_b++; last_tick_b = cyc; end
    if (valid_b === 1'b1) valids_b++;
    if (timeout_b === 1'b1) to_cyc_b++;
    if (timeout_b === 1'b1 && pto_b !== 1'b1) to_rise_b = cyc;
    pto_b = timeout_b;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    sigin = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sigin = 1'b1;
      repeat (hi) @(negedge clk);
      sigin = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    int ta, va, tb0, vb, tob;
    @(negedge clk);
    check("rst_period", period_a, 0);
    check("rst_flags", {valid_a, edge_tick_a, timeout_a}, 0);
    do_reset();
    ta = ticks_a; va = valids_a;
    wave(8, 8, 5);
    check("sq16_ticks", ticks_a - ta, 5);
    check("sq16_valids", valids_a - va, 4);
    check("sq16_period", period_a, 16);
    va = valids_a;
    wave(20, 20, 1);
    check("chg_pre", period_a, 16);
    wave(20, 20, 1);
    check("chg_first40", period_a, 40);
    wave(20, 20, 2);
    check("chg_steady40", period_a, 40);
    check("chg_valids", valids_a - va, 4);
    do_reset();
    vb = valids_b;
    wave(8, 8, 3);
    check("to_valids", valids_b - vb, 2);
    check("to_period", period_b, 16);
    repeat (120) @(negedge clk);
    check("to_level", timeout_b, 1);
    check("to_delay", to_rise_b - last_tick_b, 100);
    check("to_period_hold", period_b, 16);
    vb = valids_b; tb0 = ticks_b;
    wave(12, 12, 1);
    check("resume_to_clr", timeout_b, 0);
    check("resume_no_valid", valids_b - vb, 0);
    check("resume_tick", ticks_b - tb0, 1);
    wave(12, 12, 1);
    check("resume_valids", valids_b - vb, 1);
    check("resume_period", period_b, 24);
    do_reset();
    vb = valids_b; tob = to_cyc_b;
    wave(50, 50, 4);
    check("p100_valids", valids_b - vb, 3);
    check("p100_period", period_b, 100);
    check("p100_no_to", to_cyc_b - tob, 0);
    do_reset();
    vb = valids_b; tob = to_cyc_b;
    wave(51, 50, 3);
    check("p101_valids", valids_b - vb, 0);
    check("p101_period", period_b, 0);
    check("p101_to_seen", (to_cyc_b - tob) > 0, 1);
    do_reset();
    wave(8, 8, 2);
    check("ar_pre_period", period_a, 16);
    sigin = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_period", period_a, 0);
    check("ar_flags", {valid_a, edge_tick_a, timeout_a}, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    ta = ticks_a;
    repeat (10) @(negedge clk);
    check("hi_rel_no_tick", ticks_a - ta, 0);
    sigin = 1'b0;
    repeat (10) @(negedge clk);
    va = valids_a;
    sigin = 1'b1;
    repeat (2) @(negedge clk);
    check("lat2", edge_tick_a, 0);
    @(negedge clk);
    check("lat3", edge_tick_a, 1);
    repeat (7) @(negedge clk);
    sigin = 1'b0;
    repeat (10) @(negedge clk);
    check("ar_first_no_valid", valids_a - va, 0);
    wave(10, 10, 1);
    check("ar_second_valid", valids_a - va, 1);
    check("ar_period20", period_a, 20);
    check("no_back2back", dbl_a, 0);
    check("valid_with_tick", orphan_a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
